// File: rtl/wb_arbiter.sv
// wb_arbiter: N-master to 1-slave pipelined Wishbone arbiter with round-robin grant held for the bus cycle.
// Optional ack watchdog compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int AW              = 30,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*AW-1:0]     m_addr,
  input  logic [NUM_MASTERS*DW-1:0]     m_odata,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [NUM_MASTERS-1:0]        m_stall,
  output logic [DW-1:0]                 m_idata,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [AW-1:0]                 wb_addr,
  output logic [DW-1:0]                 wb_odata,
  output logic [DW/8-1:0]               wb_sel,
  input  logic                          wb_ack,
  input  logic                          wb_stall,
  input  logic                          wb_err,
  input  logic [DW-1:0]                 wb_idata,
  output logic [$clog2(NUM_MASTERS)-1:0] o_grant,
  output logic                          o_busy,
  output logic                          o_timeout
);
  localparam int SW = DW/8;
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant, grant_nx, last, last_nx, winner, cand;
  logic [OW-1:0] outstanding, outst_nx;
  logic          full, has_out, issue, resp, expire;

  logic [AW-1:0] addr_m [NUM_MASTERS];
  logic [DW-1:0] data_m [NUM_MASTERS];
  logic [SW-1:0] sel_m  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_m[i] = m_addr[i*AW +: AW];
    assign data_m[i] = m_odata[i*DW +: DW];
    assign sel_m[i]  = m_sel[i*SW +: SW];
  end

  assign full    = (outstanding == OW'(MAX_OUTSTANDING));
  assign has_out = (outstanding != '0);
  assign issue   = wb_stb & ~wb_stall;
  // responses arriving with nothing outstanding are dropped, not counted
  assign resp    = (wb_ack | wb_err) & has_out;

  // scan from farthest to nearest so the first requester after `last` wins
  always_comb begin
    winner = last;
    cand   = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = GW'((int'(last) + k) % NUM_MASTERS);
      if (m_cyc[cand]) winner = cand;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] wdog;

  assign expire = (state == GRANTED) && (wdog == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      wdog <= '0;
    else if (state != GRANTED || expire || !m_cyc[grant] || wb_ack || wb_err)
      wdog <= '0;
    else if (has_out)
      wdog <= wdog + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      grant       <= '0;
      last        <= GW'(NUM_MASTERS-1);
      outstanding <= '0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last        <= last_nx;
      outstanding <= outst_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    outst_nx = outstanding;
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_nx = GRANTED;
          grant_nx = winner;
          last_nx  = winner;
          outst_nx = '0;
        end
      end
      GRANTED: begin
        // pending acks of a released or expired cycle are abandoned
        if (expire || !m_cyc[grant]) begin
          state_nx = IDLE;
          outst_nx = '0;
        end else if (issue && !resp) begin
          outst_nx = outstanding + 1'b1;
        end else if (!issue && resp) begin
          outst_nx = outstanding - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    m_ack     = '0;
    m_err     = '0;
    m_stall   = '1;
    o_busy    = 1'b0;
    o_timeout = expire;
    if (state == GRANTED) begin
      o_busy = 1'b1;
      if (expire) begin
        m_err[grant] = 1'b1;
      end else begin
        wb_cyc         = m_cyc[grant];
        wb_stb         = m_stb[grant] & ~full;
        m_stall[grant] = wb_stall | full;
        m_ack[grant]   = wb_ack & has_out;
        m_err[grant]   = wb_err & has_out;
      end
    end
  end

  assign wb_we    = m_we[grant];
  assign wb_addr  = addr_m[grant];
  assign wb_odata = data_m[grant];
  assign wb_sel   = sel_m[grant];
  assign m_idata  = wb_idata;
  assign o_grant  = grant;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a cycle-level reference model.
module tb_wb_arbiter;
  localparam int N    = 2;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int SW   = DW/8;
  localparam int MAXO = 4;
  localparam int TO   = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic            clk, rst;
  logic [N-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_odata;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_idata, wb_odata, wb_idata;
  logic            wb_cyc, wb_stb, wb_we, wb_ack, wb_stall, wb_err;
  logic [AW-1:0]   wb_addr;
  logic [SW-1:0]   wb_sel;
  logic            o_grant, o_busy, o_timeout;

  wb_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_odata(m_odata), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall), .m_idata(m_idata),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr), .wb_odata(wb_odata),
    .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err), .wb_idata(wb_idata),
    .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails;
  // reference model state
  bit busy, exp_stb;
  int owner, last, outst, wdog;
  // observation counters
  int acc_cnt, ack_cnt0, ack_cnt1, err_cnt0, err_cnt1, to_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 1'b0; owner = 0; last = N-1; outst = 0; wdog = 0; exp_stb = 1'b0;
  endtask

  task automatic check_model();
    logic [N-1:0] e_ack, e_err, e_stall;
    bit e_cyc, e_to, exp_expire;
    e_ack = '0; e_err = '0; e_stall = '1; e_cyc = 1'b0; e_to = 1'b0; exp_stb = 1'b0;
    if (busy) begin
      exp_expire = TEN && (wdog == TO);
      if (exp_expire) begin
        e_err[owner] = 1'b1;
        e_to = 1'b1;
      end else begin
        e_cyc          = m_cyc[owner];
        exp_stb        = m_stb[owner] && (outst < MAXO);
        e_stall[owner] = wb_stall || (outst == MAXO);
        e_ack[owner]   = wb_ack && (outst > 0);
        e_err[owner]   = wb_err && (outst > 0);
      end
      chk("grant", 64'(o_grant), 64'(owner));
      chk("wb_addr", 64'(wb_addr), 64'(m_addr[owner*AW +: AW]));
      chk("wb_odata", 64'(wb_odata), 64'(m_odata[owner*DW +: DW]));
      chk("wb_sel", 64'(wb_sel), 64'(m_sel[owner*SW +: SW]));
      chk("wb_we", 64'(wb_we), 64'(m_we[owner]));
    end
    chk("busy", 64'(o_busy), 64'(busy));
    chk("wb_cyc", 64'(wb_cyc), 64'(e_cyc));
    chk("wb_stb", 64'(wb_stb), 64'(exp_stb));
    chk("m_ack", 64'(m_ack), 64'(e_ack));
    chk("m_err", 64'(m_err), 64'(e_err));
    chk("m_stall", 64'(m_stall), 64'(e_stall));
    chk("timeout", 64'(o_timeout), 64'(e_to));
    chk("m_idata", 64'(m_idata), 64'(wb_idata));
    acc_cnt  += int'(m_stb[0] && !m_stall[0]);
    ack_cnt0 += int'(m_ack[0]);
    ack_cnt1 += int'(m_ack[1]);
    err_cnt0 += int'(m_err[0]);
    err_cnt1 += int'(m_err[1]);
    to_cnt   += int'(o_timeout);
  endtask

  // advance the model across a clock edge using the inputs held during the cycle
  task automatic update_model();
    bit found, issue, resp;
    if (rst) begin
      model_reset();
    end else if (!busy) begin
      if (|m_cyc) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++)
          if (!found && m_cyc[(last + k) % N]) begin
            owner = (last + k) % N;
            found = 1'b1;
          end
        busy = 1'b1; last = owner; outst = 0; wdog = 0;
      end
    end else if ((TEN && wdog == TO) || !m_cyc[owner]) begin
      busy = 1'b0; outst = 0; wdog = 0;
    end else begin
      issue = exp_stb && !wb_stall;
      resp  = (wb_ack || wb_err) && (outst > 0);
      if (wb_ack || wb_err) wdog = 0;
      else if (outst > 0)   wdog++;
      outst = outst + int'(issue) - int'(resp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_counts();
    acc_cnt = 0; ack_cnt0 = 0; ack_cnt1 = 0; err_cnt0 = 0; err_cnt1 = 0; to_cnt = 0;
  endtask

  task automatic rand_payload();
    m_we     = N'($urandom);
    m_addr   = {$urandom, $urandom};
    m_odata  = {$urandom, $urandom};
    m_sel    = N*SW'($urandom);
    wb_idata = $urandom;
  endtask

  int gseq[4];
  int ng, held;
  bit prev;

  initial begin
    tests = 0; fails = 0;
    clear_counts();
    model_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0;
    wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0;
    rand_payload();
    step();
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_stall", 64'(m_stall), 64'd3);
    chk("rst_cyc", 64'(wb_cyc), 64'd0);
    rst = 1'b0;
    step();

    // both request: master 0 first, then 1 after an idle cycle
    m_cyc = 2'b11;
    step();
    chk("t1_first_grant", 64'(o_grant), 64'd0);
    chk("t1_busy", 64'(o_busy), 64'd1);
    step();
    m_cyc = 2'b10;
    step();
    chk("t1_gap_busy", 64'(o_busy), 64'd0);
    chk("t1_gap_cyc", 64'(wb_cyc), 64'd0);
    step();
    chk("t1_second_grant", 64'(o_grant), 64'd1);
    m_cyc = 2'b00;
    step();
    step();

    // depth throttle: six requests, delayed acks
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      m_stb  = (acc_cnt < 6) ? 2'b01 : 2'b00;
      wb_ack = (c == 6) || (c >= 8 && outst > 0);
      step();
      if (c == 4) begin
        chk("t2_full_stall", 64'(m_stall[0]), 64'd1);
        chk("t2_full_nostb", 64'(wb_stb), 64'd0);
      end
    end
    chk("t2_issued", 64'(acc_cnt), 64'd6);
    chk("t2_acks_m0", 64'(ack_cnt0), 64'd6);
    chk("t2_acks_m1", 64'(ack_cnt1), 64'd0);

    // spurious responses with nothing outstanding
    clear_counts();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; wb_err = 1'b1;
    step();
    wb_err = 1'b0;
    chk("t5_spur_ack", 64'(ack_cnt0 + ack_cnt1), 64'd0);
    chk("t5_spur_err", 64'(err_cnt0 + err_cnt1), 64'd0);

    // asynchronous reset while granted
    chk("t7_pre_cyc", 64'(wb_cyc), 64'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t7_async_cyc", 64'(wb_cyc), 64'd0);
    chk("t7_async_busy", 64'(o_busy), 64'd0);
    step();
    rst = 1'b0; m_cyc = '0; m_stb = '0;
    step();

    // round robin, each owner holds two cycles
    m_cyc = 2'b11; ng = 0; held = 0; prev = 1'b0;
    for (int s = 0; s < 40 && ng < 4; s++) begin
      step();
      if (o_busy && !prev) begin
        gseq[ng] = int'(o_grant);
        ng++;
      end
      prev = o_busy;
      if (o_busy) begin
        held++;
        if (held == 2) begin
          m_cyc[o_grant] = 1'b0;
          held = 0;
        end
      end else begin
        m_cyc = 2'b11;
      end
    end
    chk("t3_grants", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", 64'(gseq[i]), 64'(i % 2));
    m_cyc = '0;
    step();
    step();

    // hung slave
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    step();
    m_stb = '0;
    clear_counts();
    for (int c = 0; c < 20; c++) step();
`ifdef WB_ARB_TIMEOUT_EN
    chk("t6_timeout_pulse", 64'(to_cnt), 64'd1);
    chk("t6_err_m0", 64'(err_cnt0), 64'd1);
`else
    chk("t6_no_timeout", 64'(to_cnt), 64'd0);
    chk("t6_bus_held", 64'(wb_cyc), 64'd1);
`endif
    m_cyc = '0;
    step();
    step();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_cyc[i]) m_cyc[i] = ($urandom_range(3) == 0);
        else           m_cyc[i] = ($urandom_range(7) != 0);
        m_stb[i] = m_cyc[i] && $urandom_range(1);
      end
      rand_payload();
      wb_stall = ($urandom_range(3) == 0);
      wb_ack   = ($urandom_range(2) == 0);
      wb_err   = ($urandom_range(19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
